// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE  : datapath slice width processed per clock
//   state_t : control FSM states (IDLE, RUN, DONE)
package nibble_serial_pkg;

   localparam int unsigned NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla_nibble.sv
// Gate-level 4-bit carry-lookahead adder slice.
//   A, B  in  [3:0]  nibble operands
//   cin   in         carry into bit 0
//   s     out [3:0]  nibble sum
//   cout  out        carry out of bit 3
//   c3    out        carry into bit 3 (used for signed overflow)
module cla_nibble (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       c3
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic       w_c1;
   logic       w_c2;
   logic       w_c3;
   logic       w_c4;

   assign w_g = A & B;
   assign w_p = A ^ B;

   // Every carry is expanded flat from cin so no carry waits on another.
   assign w_c1 = w_g[0]
               | (w_p[0] & cin);
   assign w_c2 = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & cin);
   assign w_c3 = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
   assign w_c4 = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

   assign s    = w_p ^ {w_c3, w_c2, w_c1, cin};
   assign cout = w_c4;
   assign c3   = w_c3;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one nibble per clock through a
// single CLA slice, holding the inter-nibble carry in a flop.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = state IDLE)
//   a, b, cin           operands and carry into nibble 0
//   sub                 subtract request (only with NIBBLE_SERIAL_SUB_EN)
//   out_valid/out_ready result handshake (out_valid = state DONE)
//   sum, cout, ovf      result, carry out of MSB, signed overflow
// Optional feature macro: NIBBLE_SERIAL_SUB_EN (adds sub port, a + ~b + 1).
module nibble_serial_adder
   import nibble_serial_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NNIB = WIDTH / NIBBLE;
   localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

   generate
      if (((WIDTH % NIBBLE) != 0) || (WIDTH < NIBBLE)) begin : g_bad_width
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic [3:0]       w_b_nib;
   logic [3:0]       w_s;
   logic             w_cout;
   logic             w_c3;
   logic             w_last;
   logic [WIDTH+3:0] w_sum_cat;

`ifdef NIBBLE_SERIAL_SUB_EN
   logic             r_sub;
   assign w_b_nib = r_b[3:0] ^ {4{r_sub}};
`else
   assign w_b_nib = r_b[3:0];
`endif

   cla_nibble u_cla (
      .A    (r_a[3:0]),
      .B    (w_b_nib),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout),
      .c3   (w_c3)
   );

   assign w_last    = (r_cnt == CW'(NNIB - 1));
   // New nibble enters at the top; concatenating then dropping the low
   // nibble also works when WIDTH == 4.
   assign w_sum_cat = {w_s, r_sum};

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
         r_sub   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_cnt <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                  r_sub   <= sub;
                  r_carry <= sub ? 1'b1 : cin;
`else
                  r_carry <= cin;
`endif
               end
            end
            RUN: begin
               r_a     <= r_a >> NIBBLE;
               r_b     <= r_b >> NIBBLE;
               r_sum   <= w_sum_cat[WIDTH+3:NIBBLE];
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_cout <= w_cout;
                  r_ovf  <= w_cout ^ w_c3;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule
